// File: rtl/riscv_tag_commit_unit.sv
// DIFT tag commit/check unit: 1-bit tag register file with same-cycle bypass, PC tag,
// and a tainted-control-flow trap FSM with a request/acknowledge handshake.
module riscv_tag_commit_unit #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic             ex_ready_i,
  input  logic             branch_in_ex_i,
  input  logic             branch_decision_i,
  input  logic [4:0]       ex_waddr_i,
  input  logic             ex_we_tag_i,
  input  logic             ex_wdata_tag_i,
  input  logic             jump_target_tag_i,
  input  logic             pc_enable_tag_i,
  input  logic [4:0]       wb_waddr_i,
  input  logic             wb_we_tag_i,
  input  logic             wb_wdata_tag_i,
  input  logic [4:0]       raddr_a_i,
  input  logic [4:0]       raddr_b_i,
  input  logic [4:0]       raddr_c_i,
  output logic             rdata_a_tag_o,
  output logic             rdata_b_tag_o,
  output logic             rdata_c_tag_o,
  input  logic             check_en_i,
  output logic             pc_tag_o,
  output logic             trap_req_o,
  output logic [1:0]       trap_cause_o,
  input  logic             trap_ack_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] trap_count_o
);

  typedef enum logic [1:0] {StIdle, StReq, StClr} state_e;

  state_e             state_q, state_d;
  logic [NREGS-1:0]   tag_q, tag_d;
  logic               pc_tag_q, pc_tag_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic ex_we;
  logic bc;
  logic ev_jump;
  logic ev_pc;

  assign ex_we   = ex_valid_i & ex_we_tag_i;
  assign bc      = branch_in_ex_i & ex_ready_i & branch_decision_i;
  assign ev_jump = bc & pc_enable_tag_i & jump_target_tag_i;
  assign ev_pc   = ex_valid_i & pc_tag_q;

  // EX is applied after WB so it wins on an address collision.
  always_comb begin
    tag_d = tag_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wb_we_tag_i && (wb_waddr_i == 5'(i))) tag_d[i] = wb_wdata_tag_i;
      if (ex_we && (ex_waddr_i == 5'(i)))       tag_d[i] = ex_wdata_tag_i;
    end
    tag_d[0] = 1'b0;
  end

  function automatic logic read_tag(input logic [4:0] addr);
    logic val;
    if (addr == 5'd0) begin
      val = 1'b0;
    end else if (ex_we && (ex_waddr_i == addr)) begin
      val = ex_wdata_tag_i;
    end else if (wb_we_tag_i && (wb_waddr_i == addr)) begin
      val = wb_wdata_tag_i;
    end else begin
      val = tag_q[addr];
    end
    return val;
  endfunction

  assign rdata_a_tag_o = read_tag(raddr_a_i);
  assign rdata_b_tag_o = read_tag(raddr_b_i);
  assign rdata_c_tag_o = read_tag(raddr_c_i);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pc_tag_d = pc_tag_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bc && pc_enable_tag_i) pc_tag_d = jump_target_tag_i;
        if (check_en_i && (ev_jump || ev_pc)) begin
          state_d = StReq;
          cause_d = ev_jump ? 2'b01 : 2'b10;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StReq: begin
        if (trap_ack_i) state_d = StClr;
      end
      StClr: begin
        pc_tag_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      pc_tag_q <= 1'b0;
      cause_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      pc_tag_q <= pc_tag_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_tag_o     = pc_tag_q;
  assign trap_req_o   = (state_q == StReq);
  assign stall_o      = (state_q != StIdle);
  assign trap_cause_o = cause_q;
  assign trap_count_o = cnt_q;

endmodule

// File: tb/tb_riscv_tag_commit_unit.sv
// Directed self-checking bench for riscv_tag_commit_unit: bypass, trap handshake,
// policy enable, priority/drop, reset mid-trap and counter saturation.
module tb_riscv_tag_commit_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid_i, ex_ready_i, branch_in_ex_i, branch_decision_i;
  logic [4:0] ex_waddr_i, wb_waddr_i, raddr_a_i, raddr_b_i, raddr_c_i;
  logic       ex_we_tag_i, ex_wdata_tag_i, jump_target_tag_i, pc_enable_tag_i;
  logic       wb_we_tag_i, wb_wdata_tag_i;
  logic       rdata_a_tag_o, rdata_b_tag_o, rdata_c_tag_o;
  logic       check_en_i, pc_tag_o, trap_req_o, trap_ack_i, stall_o;
  logic [1:0] trap_cause_o;
  logic [7:0] trap_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_tag_commit_unit #(.NREGS(32), .CNT_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid_i        (ex_valid_i),
    .ex_ready_i        (ex_ready_i),
    .branch_in_ex_i    (branch_in_ex_i),
    .branch_decision_i (branch_decision_i),
    .ex_waddr_i        (ex_waddr_i),
    .ex_we_tag_i       (ex_we_tag_i),
    .ex_wdata_tag_i    (ex_wdata_tag_i),
    .jump_target_tag_i (jump_target_tag_i),
    .pc_enable_tag_i   (pc_enable_tag_i),
    .wb_waddr_i        (wb_waddr_i),
    .wb_we_tag_i       (wb_we_tag_i),
    .wb_wdata_tag_i    (wb_wdata_tag_i),
    .raddr_a_i         (raddr_a_i),
    .raddr_b_i         (raddr_b_i),
    .raddr_c_i         (raddr_c_i),
    .rdata_a_tag_o     (rdata_a_tag_o),
    .rdata_b_tag_o     (rdata_b_tag_o),
    .rdata_c_tag_o     (rdata_c_tag_o),
    .check_en_i        (check_en_i),
    .pc_tag_o          (pc_tag_o),
    .trap_req_o        (trap_req_o),
    .trap_cause_o      (trap_cause_o),
    .trap_ack_i        (trap_ack_i),
    .stall_o           (stall_o),
    .trap_count_o      (trap_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    ex_valid_i = 0; ex_ready_i = 0; branch_in_ex_i = 0; branch_decision_i = 0;
    ex_waddr_i = 0; ex_we_tag_i = 0; ex_wdata_tag_i = 0; jump_target_tag_i = 0;
    pc_enable_tag_i = 0; wb_waddr_i = 0; wb_we_tag_i = 0; wb_wdata_tag_i = 0;
    trap_ack_i = 0;
  endtask

  task automatic branch(input logic taken, input logic pen, input logic jt);
    branch_in_ex_i = 1; ex_ready_i = 1; branch_decision_i = taken;
    pc_enable_tag_i = pen; jump_target_tag_i = jt;
  endtask

  // Set pc_tag to 1 with the policy off, leaving check_en low.
  task automatic taint_pc();
    check_en_i = 0;
    branch(1, 1, 1);
    step();
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    check_en_i = 0; raddr_a_i = 5; raddr_b_i = 7; raddr_c_i = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", trap_req_o, 0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_pc_tag", pc_tag_o, 0);
    check_eq("rst_cause", trap_cause_o, 0);
    check_eq("rst_count", trap_count_o, 0);
    check_eq("rst_rd_a", rdata_a_tag_o, 0);
    rst_n = 1;
    step();

    // EX and WB collide on x5, WB also writes x7, EX write to x0 discarded.
    ex_valid_i = 1; ex_we_tag_i = 1; ex_waddr_i = 5; ex_wdata_tag_i = 1;
    wb_we_tag_i = 1; wb_waddr_i = 5; wb_wdata_tag_i = 0;
    #1;
    check_eq("byp_ex_wins", rdata_a_tag_o, 1);
    wb_waddr_i = 7; wb_wdata_tag_i = 1;
    #1;
    check_eq("byp_wb", rdata_b_tag_o, 1);
    wb_waddr_i = 5; wb_wdata_tag_i = 0;
    step();
    clr_inputs();
    check_eq("stored_x5", rdata_a_tag_o, 1);
    check_eq("x7_not_written", rdata_b_tag_o, 0);
    wb_we_tag_i = 1; wb_waddr_i = 7; wb_wdata_tag_i = 1;
    ex_valid_i = 1; ex_we_tag_i = 1; ex_waddr_i = 0; ex_wdata_tag_i = 1;
    #1;
    check_eq("x0_bypass", rdata_c_tag_o, 0);
    step();
    clr_inputs();
    check_eq("stored_x7", rdata_b_tag_o, 1);
    check_eq("x0_stored", rdata_c_tag_o, 0);
    // EX write without ex_valid is not a write.
    ex_we_tag_i = 1; ex_waddr_i = 5; ex_wdata_tag_i = 0;
    #1;
    check_eq("ex_ungated_byp", rdata_a_tag_o, 1);
    step();
    clr_inputs();
    check_eq("ex_ungated_store", rdata_a_tag_o, 1);

    // Tainted jump target trap.
    check_en_i = 1;
    branch(1, 1, 1);
    step();
    clr_inputs();
    check_eq("j_req", trap_req_o, 1);
    check_eq("j_cause", trap_cause_o, 2'b01);
    check_eq("j_stall", stall_o, 1);
    check_eq("j_count", trap_count_o, 1);
    step();
    step();
    check_eq("j_hold_req", trap_req_o, 1);
    trap_ack_i = 1;
    step();
    trap_ack_i = 0;
    check_eq("j_clr_req", trap_req_o, 0);
    check_eq("j_clr_stall", stall_o, 1);
    step();
    check_eq("j_idle_stall", stall_o, 0);
    check_eq("j_idle_pc", pc_tag_o, 0);
    check_eq("j_idle_count", trap_count_o, 1);

    // Policy off: PC becomes tainted without trapping; then commit traps with cause 10.
    taint_pc();
    check_eq("off_no_req", trap_req_o, 0);
    check_eq("off_pc_tag", pc_tag_o, 1);
    check_en_i = 1; ex_valid_i = 1;
    step();
    clr_inputs();
    check_eq("pc_req", trap_req_o, 1);
    check_eq("pc_cause", trap_cause_o, 2'b10);
    check_eq("pc_count", trap_count_o, 2);
    trap_ack_i = 1;
    step();
    trap_ack_i = 0;
    step();
    check_eq("pc_idle_pc", pc_tag_o, 0);

    // E1 and E2 together, then further events dropped while in REQ.
    taint_pc();
    check_en_i = 1; ex_valid_i = 1;
    branch(1, 1, 1);
    step();
    check_eq("pri_cause", trap_cause_o, 2'b01);
    check_eq("pri_count", trap_count_o, 3);
    branch(1, 1, 0);
    step();
    clr_inputs();
    check_eq("drop_count", trap_count_o, 3);
    check_eq("req_pc_frozen", pc_tag_o, 1);
    trap_ack_i = 1;
    step();
    trap_ack_i = 0;
    step();
    check_eq("pri_idle_count", trap_count_o, 3);
    trap_ack_i = 1;
    step();
    trap_ack_i = 0;
    check_eq("ack_ignored", stall_o, 0);

    // Not-taken branch and disabled pc update leave pc_tag alone.
    taint_pc();
    branch(0, 1, 0);
    step();
    clr_inputs();
    check_eq("nt_pc_tag", pc_tag_o, 1);
    branch(1, 0, 0);
    step();
    clr_inputs();
    check_eq("pen0_pc_tag", pc_tag_o, 1);

    // Reset while a trap is pending.
    check_en_i = 1; ex_valid_i = 1;
    step();
    clr_inputs();
    check_eq("pre_rst_req", trap_req_o, 1);
    rst_n = 0;
    #1;
    check_eq("mid_rst_req", trap_req_o, 0);
    check_eq("mid_rst_stall", stall_o, 0);
    check_eq("mid_rst_x5", rdata_a_tag_o, 0);
    check_eq("mid_rst_x7", rdata_b_tag_o, 0);
    check_eq("mid_rst_count", trap_count_o, 0);
    step();
    rst_n = 1;
    step();

    // Counter saturation.
    check_en_i = 1;
    for (int n = 1; n <= 256; n++) begin
      branch(1, 1, 1);
      step();
      clr_inputs();
      trap_ack_i = 1;
      step();
      trap_ack_i = 0;
      step();
      if (n == 255) check_eq("count_255", trap_count_o, 255);
    end
    check_eq("count_sat", trap_count_o, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
